// File: rtl/fft_pkg.sv
// Shared types for the butterfly operand loader: sequencer states, packet
// length and the byte-order map from flag index to operand.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_W,
        LD_REB,
        LD_IMB,
        LD_REA,
        LD_IMA,
        FIRE
    } seq_state_t;

    localparam int PKT_BYTES = 5;

    // Flag index i (f1 = index 0) captures operand i of the packet.
    localparam int OP_W   = 0;
    localparam int OP_REB = 1;
    localparam int OP_IMB = 2;
    localparam int OP_REA = 3;
    localparam int OP_IMA = 4;

    function automatic logic is_load(seq_state_t s);
        return (s == LD_W) || (s == LD_REB) || (s == LD_IMB) ||
               (s == LD_REA) || (s == LD_IMA);
    endfunction

    function automatic logic [PKT_BYTES-1:0] load_flags(seq_state_t s);
        logic [PKT_BYTES-1:0] f;
        f = '0;
        case (s)
            LD_W:    f[OP_W]   = 1'b1;
            LD_REB:  f[OP_REB] = 1'b1;
            LD_IMB:  f[OP_IMB] = 1'b1;
            LD_REA:  f[OP_REA] = 1'b1;
            LD_IMA:  f[OP_IMA] = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fft_load_seq_if.sv
// Byte-source / butterfly handshake bundle between the environment (master)
// and the load sequencer (slave).
interface fft_load_seq_if #(
    parameter int IDX_W = 2
) ();
    logic             en;
    logic             readyin;
    logic             bf_busy;
    logic             rdy_out;
    logic             f1;
    logic             f2;
    logic             f3;
    logic             f4;
    logic             f5;
    logic             readyin_1;
    logic             bf_start;
    logic [IDX_W-1:0] bf_idx;
    logic             frame_done;
    logic             timeout_err;

    modport master (
        output en, readyin, bf_busy,
        input  rdy_out, f1, f2, f3, f4, f5, readyin_1,
               bf_start, bf_idx, frame_done, timeout_err
    );

    modport slave (
        input  en, readyin, bf_busy,
        output rdy_out, f1, f2, f3, f4, f5, readyin_1,
               bf_start, bf_idx, frame_done, timeout_err
    );
endinterface

// File: rtl/fft_gap_timer.sv
// Idle-gap counter: counts i_inc cycles since the last i_clear and flags the
// cycle in which the count would reach LIMIT (LIMIT = 0 never expires).
module fft_gap_timer #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic n_rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);
    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);
    localparam logic ENABLED = (LIMIT > 0);

    logic [CW-1:0] r_cnt;

    assign o_expire = ENABLED && i_inc && (r_cnt == LAST);

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_clear || o_expire) begin
            r_cnt <= '0;
        end else if (i_inc && ENABLED) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fft_load_seq.sv
// Butterfly load sequencer: turns the readyin byte strobe into one-hot operand
// capture flags, launches a butterfly per 5-byte packet and counts per frame.
module fft_load_seq
    import fft_pkg::*;
#(
    parameter int NUM_BF  = 4,
    parameter int TIMEOUT = 16,
    parameter int IDX_W   = (NUM_BF > 1) ? $clog2(NUM_BF) : 1
) (
    input  logic          clock,
    input  logic          n_rst,
    fft_load_seq_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BF - 1);

    seq_state_t           r_state;
    seq_state_t           w_nxt_state;
    logic [PKT_BYTES-1:0] r_flags;
    logic                 r_rdy;
    logic                 r_fire;
    logic                 r_terr;
    logic [IDX_W-1:0]     r_idx;

    logic w_in_gap;
    logic w_inc;
    logic w_clr;
    logic w_expire;
    logic w_start;
    logic w_last;

    // LD_W waits for a packet indefinitely; only mid-packet gaps are timed.
    assign w_in_gap = (r_state == LD_REB) || (r_state == LD_IMB) ||
                      (r_state == LD_REA) || (r_state == LD_IMA);
    assign w_inc    = w_in_gap && !bus.readyin;
    assign w_clr    = !w_in_gap || bus.readyin;
    assign w_start  = r_fire && !bus.bf_busy;
    assign w_last   = (r_idx == LAST_IDX);

    fft_gap_timer #(
        .LIMIT(TIMEOUT)
    ) u_gap (
        .clock   (clock),
        .n_rst   (n_rst),
        .i_clear (w_clr),
        .i_inc   (w_inc),
        .o_expire(w_expire)
    );

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            IDLE:    if (bus.en) w_nxt_state = LD_W;
            LD_W:    if (bus.readyin) w_nxt_state = LD_REB;
            LD_REB:  if (bus.readyin) w_nxt_state = LD_IMB;
                     else if (w_expire) w_nxt_state = LD_W;
            LD_IMB:  if (bus.readyin) w_nxt_state = LD_REA;
                     else if (w_expire) w_nxt_state = LD_W;
            LD_REA:  if (bus.readyin) w_nxt_state = LD_IMA;
                     else if (w_expire) w_nxt_state = LD_W;
            LD_IMA:  if (bus.readyin) w_nxt_state = FIRE;
                     else if (w_expire) w_nxt_state = LD_W;
            FIRE:    if (w_start) w_nxt_state = w_last ? IDLE : LD_W;
            default: w_nxt_state = IDLE;
        endcase
    end

    // Flags and ready are decoded from the next state so they are registered
    // and valid for the whole cycle the loader samples them.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_flags <= '0;
            r_rdy   <= 1'b0;
            r_fire  <= 1'b0;
            r_terr  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_flags <= load_flags(w_nxt_state);
            r_rdy   <= is_load(w_nxt_state);
            r_fire  <= (w_nxt_state == FIRE);
            r_terr  <= w_expire;
            if (w_start) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign bus.rdy_out     = r_rdy;
    assign bus.readyin_1   = r_rdy;
    assign bus.f1          = r_flags[OP_W];
    assign bus.f2          = r_flags[OP_REB];
    assign bus.f3          = r_flags[OP_IMB];
    assign bus.f4          = r_flags[OP_REA];
    assign bus.f5          = r_flags[OP_IMA];
    assign bus.bf_start    = w_start;
    assign bus.frame_done  = w_start && w_last;
    assign bus.timeout_err = r_terr;
    assign bus.bf_idx      = r_idx;
endmodule

// File: tb/tb_fft_load_seq.sv
// Directed bench for fft_load_seq: packet loading, busy stalls, frame wrap,
// inter-byte timeout, late byte and asynchronous reset mid-packet.
module tb_fft_load_seq;
    logic clock = 1'b0;
    logic n_rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clock = ~clock;

    fft_load_seq_if #(.IDX_W(2)) bus ();

    fft_load_seq #(
        .NUM_BF (4),
        .TIMEOUT(16),
        .IDX_W  (2)
    ) dut (
        .clock(clock),
        .n_rst(n_rst),
        .bus  (bus)
    );

    logic [4:0] flg;
    assign flg = {bus.f1, bus.f2, bus.f3, bus.f4, bus.f5};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_outs(input string tag, input logic [4:0] f, input logic rdy,
                            input logic st, input logic fd, input logic te,
                            input logic [1:0] idx);
        chk({tag, ".flags"}, 32'(flg), 32'(f));
        chk({tag, ".rdy_out"}, 32'(bus.rdy_out), 32'(rdy));
        chk({tag, ".readyin_1"}, 32'(bus.readyin_1), 32'(rdy));
        chk({tag, ".bf_start"}, 32'(bus.bf_start), 32'(st));
        chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(fd));
        chk({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(te));
        chk({tag, ".bf_idx"}, 32'(bus.bf_idx), 32'(idx));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic e, input logic r, input logic b);
        bus.en      = e;
        bus.readyin = r;
        bus.bf_busy = b;
        #1;
    endtask

    // Starts in LD_W; leaves in LD_W (or IDLE after the last butterfly).
    task automatic send_pkt(input int stall, input logic [1:0] idx, input logic last);
        logic [4:0] f;
        f = 5'b10000;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            chk_outs($sformatf("load%0d_b%0d", idx, k), f, 1'b1, 1'b0, 1'b0, 1'b0, idx);
            f = f >> 1;
            tick();
        end
        for (int s = 0; s < stall; s++) begin
            drive(1'b0, 1'b1, 1'b1);
            chk_outs($sformatf("stall%0d_%0d", idx, s), 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, idx);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0);
        chk_outs($sformatf("fire%0d", idx), 5'b0, 1'b0, 1'b1, last, 1'b0, idx);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.en = 1'b0;
        bus.readyin = 1'b0;
        bus.bf_busy = 1'b0;
        #2 n_rst = 1'b0;
        #10;
        chk_outs("reset", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        n_rst = 1'b1;
        tick();

        // Frame 1: four packets, the second stalled by bf_busy for 3 cycles
        drive(1'b1, 1'b0, 1'b0);
        chk_outs("idle", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        send_pkt(0, 2'd0, 1'b0);
        send_pkt(3, 2'd1, 1'b0);
        send_pkt(0, 2'd2, 1'b0);
        send_pkt(0, 2'd3, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        chk_outs("frame_end", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_outs("idle_hold", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Frame 2: one packet, then a timed-out partial packet
        drive(1'b1, 1'b0, 1'b0);
        tick();
        send_pkt(0, 2'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        chk_outs("to_w", 5'b10000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        chk_outs("to_reb", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            chk_outs($sformatf("gap%0d", i), 5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        chk_outs("timeout", 5'b10000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        chk_outs("after_to", 5'b10000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        tick();

        // Byte arriving on the 16th idle cycle wins over the timeout
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            chk_outs($sformatf("lgap%0d", i), 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0);
        chk_outs("late_byte", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        chk_outs("late_acc", 5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        chk_outs("late_rea", 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        chk_outs("late_ima", 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        chk_outs("late_fire", 5'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        tick();

        // Reset while in LD_REA of packet 2
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        chk_outs("pre_rst", 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        n_rst = 1'b0;
        #1;
        chk_outs("async_rst", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        #1 n_rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        chk_outs("rst_idle", 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0);
        chk_outs("restart_w", 5'b10000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk_outs("restart_reb", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
